// File: rtl/hd_transfer_ctrl_pkg.sv
// Shared constants and types for the disk <-> memory block-copy controller.
// Widths and region sizes also appear in the OS memory map.
package hd_ctrl_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned DISK_SIZE      = 4096;
  localparam int unsigned MEM_ADDR_WIDTH = 15;
  localparam int unsigned CNT_WIDTH      = 13;
  localparam int unsigned REGION         = 2048;

  localparam logic DIR_LOAD  = 1'b0;
  localparam logic DIR_STORE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    READ,
    WRITE,
    FINISH
  } state_e;

endpackage

// File: rtl/hd_transfer_ctrl_if.sv
// Request, status, disk and memory signals of the transfer controller.
// The controller is master of both the disk and the memory ports.
interface hd_transfer_ctrl_if;
  import hd_ctrl_pkg::*;

  logic                      start;
  logic                      dir;
  logic [DATA_WIDTH-1:0]     disk_base;
  logic [MEM_ADDR_WIDTH-1:0] mem_base;
  logic [CNT_WIDTH-1:0]      word_count;

  logic [DATA_WIDTH-1:0]     hd_address;
  logic                      hd_write_flag;
  logic [DATA_WIDTH-1:0]     hd_input_data;
  logic [DATA_WIDTH-1:0]     hd_output;

  logic [MEM_ADDR_WIDTH-1:0] mem_address;
  logic                      mem_write;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  logic                      busy;
  logic                      done;
  logic                      error;

  modport master (
    input  start, dir, disk_base, mem_base, word_count, hd_output, mem_rdata,
    output hd_address, hd_write_flag, hd_input_data,
    output mem_address, mem_write, mem_wdata,
    output busy, done, error
  );

  modport slave (
    output start, dir, disk_base, mem_base, word_count, hd_output, mem_rdata,
    input  hd_address, hd_write_flag, hd_input_data,
    input  mem_address, mem_write, mem_wdata,
    input  busy, done, error
  );

endinterface

// File: rtl/hd_transfer_ctrl.sv
// Copies word_count words between disk and memory, one word per READ/WRITE pair.
// Bounds are checked once up front; a rejected request pulses error and writes nothing.
module hd_transfer_ctrl
  import hd_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  hd_transfer_ctrl_if.master bus
);

  localparam int unsigned SUM_W     = DATA_WIDTH + 1;
  localparam int unsigned MEM_WORDS = 1 << MEM_ADDR_WIDTH;

  state_e                    state, state_nxt;
  logic [CNT_WIDTH-1:0]      idx, idx_nxt;
  logic                      dir_q;
  logic [DATA_WIDTH-1:0]     disk_base_q;
  logic [MEM_ADDR_WIDTH-1:0] mem_base_q;
  logic [CNT_WIDTH-1:0]      count_q;

  logic [DATA_WIDTH-1:0]     hd_addr_q, hd_addr_nxt;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_nxt;
  logic                      hd_we_q, hd_we_nxt;
  logic                      mem_we_q, mem_we_nxt;
  logic                      busy_q, busy_nxt;
  logic                      done_q, done_nxt;
  logic                      error_q, error_nxt;

  logic disk_oob_c, mem_oob_c;

  // Sums carry one extra bit so a large base cannot wrap past the limit.
  assign disk_oob_c = (SUM_W'(disk_base_q) + SUM_W'(count_q)) > SUM_W'(DISK_SIZE);
  assign mem_oob_c  = (SUM_W'(mem_base_q) + SUM_W'(count_q)) > SUM_W'(MEM_WORDS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      dir_q       <= DIR_LOAD;
      disk_base_q <= '0;
      mem_base_q  <= '0;
      count_q     <= '0;
      hd_addr_q   <= '0;
      mem_addr_q  <= '0;
      hd_we_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      hd_addr_q  <= hd_addr_nxt;
      mem_addr_q <= mem_addr_nxt;
      hd_we_q    <= hd_we_nxt;
      mem_we_q   <= mem_we_nxt;
      busy_q     <= busy_nxt;
      done_q     <= done_nxt;
      error_q    <= error_nxt;
      if (state == IDLE && bus.start) begin
        dir_q       <= bus.dir;
        disk_base_q <= bus.disk_base;
        mem_base_q  <= bus.mem_base;
        count_q     <= bus.word_count;
      end
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    logic [DATA_WIDTH-1:0]     disk_addr;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;

    state_nxt    = state;
    idx_nxt      = idx;
    hd_addr_nxt  = hd_addr_q;
    mem_addr_nxt = mem_addr_q;
    hd_we_nxt    = 1'b0;
    mem_we_nxt   = 1'b0;
    error_nxt    = 1'b0;
    disk_addr    = '0;
    mem_addr     = '0;

    case (state)
      IDLE: begin
        if (bus.start) state_nxt = CHECK;
      end
      CHECK: begin
        if (disk_oob_c || mem_oob_c) begin
          error_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (count_q == '0) begin
          state_nxt = FINISH;
        end else begin
          idx_nxt   = '0;
          state_nxt = READ;
        end
      end
      READ: begin
        state_nxt = WRITE;
      end
      WRITE: begin
        idx_nxt   = idx + CNT_WIDTH'(1);
        state_nxt = (idx_nxt == count_q) ? FINISH : READ;
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    disk_addr = disk_base_q + DATA_WIDTH'(idx_nxt);
    mem_addr  = mem_base_q + MEM_ADDR_WIDTH'(idx_nxt);

    if (state_nxt == READ) begin
      if (dir_q == DIR_LOAD) hd_addr_nxt  = disk_addr;
      else                   mem_addr_nxt = mem_addr;
    end

    if (state_nxt == WRITE) begin
      if (dir_q == DIR_LOAD) begin
        mem_addr_nxt = mem_addr;
        mem_we_nxt   = 1'b1;
      end else begin
        hd_addr_nxt = disk_addr;
        hd_we_nxt   = 1'b1;
      end
    end

    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == FINISH);
  end

  assign bus.hd_address    = hd_addr_q;
  assign bus.hd_write_flag = hd_we_q;
  assign bus.mem_address   = mem_addr_q;
  assign bus.mem_write     = mem_we_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.error         = error_q;

  // Source read data only arrives during WRITE, so write data is a gated pass-through.
  assign bus.mem_wdata     = mem_we_q ? bus.hd_output : '0;
  assign bus.hd_input_data = hd_we_q  ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_hd_transfer_ctrl.sv
// Directed bench for hd_transfer_ctrl with behavioural disk and memory models.
module tb_hd_transfer_ctrl;
  import hd_ctrl_pkg::*;

  localparam int unsigned MEM_WORDS = 1 << MEM_ADDR_WIDTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hd_transfer_ctrl_if bus ();

  hd_transfer_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int checks = 0;
  int errors = 0;

  logic [DATA_WIDTH-1:0] disk_m [0:DISK_SIZE-1];
  logic [DATA_WIDTH-1:0] mem_m  [0:MEM_WORDS-1];

  int mem_wr_cnt  = 0;
  int hd_wr_cnt   = 0;
  int both_wr_cnt = 0;
  int hd_oob_cnt  = 0;
  int done_cnt    = 0;

  // Registered-read disk and memory, plus write bookkeeping.
  always @(posedge clk) begin
    bus.hd_output <= disk_m[bus.hd_address[11:0]];
    bus.mem_rdata <= mem_m[bus.mem_address];
    if (bus.mem_write) begin
      mem_m[bus.mem_address] <= bus.mem_wdata;
      mem_wr_cnt++;
    end
    if (bus.hd_write_flag) begin
      if (bus.hd_address >= DISK_SIZE) hd_oob_cnt++;
      else disk_m[bus.hd_address[11:0]] <= bus.hd_input_data;
      hd_wr_cnt++;
    end
    if (bus.mem_write && bus.hd_write_flag) both_wr_cnt++;
    if (bus.done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request and observe a fixed window; offsets count cycles after start is sampled.
  task automatic run(input logic d, input logic [DATA_WIDTH-1:0] db,
                     input logic [MEM_ADDR_WIDTH-1:0] mb, input logic [CNT_WIDTH-1:0] cnt,
                     input int restart_at,
                     output int done_at, output int err_at, output int busy_cycles);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.dir        = d;
    bus.disk_base  = db;
    bus.mem_base   = mb;
    bus.word_count = cnt;
    @(posedge clk);
    #1 bus.start = 1'b0;
    done_at     = -1;
    err_at      = -1;
    busy_cycles = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus.busy) busy_cycles++;
      if (bus.done && done_at < 0) done_at = k;
      if (bus.error && err_at < 0) err_at = k;
      if (k == restart_at) begin
        bus.start      = 1'b1;
        bus.dir        = ~d;
        bus.disk_base  = '0;
        bus.mem_base   = '0;
        bus.word_count = CNT_WIDTH'(1);
      end else begin
        bus.start = 1'b0;
      end
    end
  endtask

  int done_at, err_at, busy_cycles;
  int mw0, hw0, dn0;

  initial begin
    for (int i = 0; i < int'(DISK_SIZE); i++) disk_m[i] = '0;
    for (int i = 0; i < int'(MEM_WORDS); i++) mem_m[i] = '0;
    bus.start      = 1'b0;
    bus.dir        = DIR_LOAD;
    bus.disk_base  = '0;
    bus.mem_base   = '0;
    bus.word_count = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_hd_address", bus.hd_address, 32'h0);
    chk("rst_hd_write_flag", 32'(bus.hd_write_flag), 32'h0);
    chk("rst_hd_input_data", bus.hd_input_data, 32'h0);
    chk("rst_mem_address", 32'(bus.mem_address), 32'h0);
    chk("rst_mem_write", 32'(bus.mem_write), 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_error", 32'(bus.error), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Load 4 words from disk 0 into the process region
    disk_m[0] = 32'h11; disk_m[1] = 32'h22; disk_m[2] = 32'h33; disk_m[3] = 32'h44;
    mw0 = mem_wr_cnt; hw0 = hd_wr_cnt; dn0 = done_cnt;
    run(DIR_LOAD, 32'd0, MEM_ADDR_WIDTH'(REGION), CNT_WIDTH'(4), -1, done_at, err_at, busy_cycles);
    chk("load_done_at", done_at, 32'd10);
    chk("load_err_at", err_at, 32'hFFFF_FFFF);
    chk("load_busy_cycles", busy_cycles, 32'd10);
    chk("load_mem_writes", mem_wr_cnt - mw0, 32'd4);
    chk("load_hd_writes", hd_wr_cnt - hw0, 32'd0);
    chk("load_done_pulses", done_cnt - dn0, 32'd1);
    chk("load_m0", mem_m[REGION + 0], 32'h11);
    chk("load_m1", mem_m[REGION + 1], 32'h22);
    chk("load_m2", mem_m[REGION + 2], 32'h33);
    chk("load_m3", mem_m[REGION + 3], 32'h44);
    chk("load_hd_addr_hold", bus.hd_address, 32'd3);
    chk("load_mem_addr_hold", 32'(bus.mem_address), 32'd2051);

    // Store 3 words to the very end of the disk
    mem_m[100] = 32'hA; mem_m[101] = 32'hB; mem_m[102] = 32'hC;
    mw0 = mem_wr_cnt; hw0 = hd_wr_cnt;
    run(DIR_STORE, 32'd4093, MEM_ADDR_WIDTH'(100), CNT_WIDTH'(3), -1, done_at, err_at, busy_cycles);
    chk("store_done_at", done_at, 32'd8);
    chk("store_hd_writes", hd_wr_cnt - hw0, 32'd3);
    chk("store_mem_writes", mem_wr_cnt - mw0, 32'd0);
    chk("store_d4093", disk_m[4093], 32'hA);
    chk("store_d4094", disk_m[4094], 32'hB);
    chk("store_d4095", disk_m[4095], 32'hC);
    chk("store_hd_oob", hd_oob_cnt, 32'd0);

    // Disk bound exceeded by one word
    mw0 = mem_wr_cnt; hw0 = hd_wr_cnt; dn0 = done_cnt;
    run(DIR_LOAD, 32'd4090, MEM_ADDR_WIDTH'(0), CNT_WIDTH'(7), -1, done_at, err_at, busy_cycles);
    chk("dbound_err_at", err_at, 32'd2);
    chk("dbound_done_at", done_at, 32'hFFFF_FFFF);
    chk("dbound_busy_cycles", busy_cycles, 32'd1);
    chk("dbound_writes", (mem_wr_cnt - mw0) + (hd_wr_cnt - hw0), 32'd0);

    // Memory bound exceeded
    mw0 = mem_wr_cnt; hw0 = hd_wr_cnt;
    run(DIR_STORE, 32'd0, MEM_ADDR_WIDTH'(32760), CNT_WIDTH'(10), -1, done_at, err_at, busy_cycles);
    chk("mbound_err_at", err_at, 32'd2);
    chk("mbound_writes", (mem_wr_cnt - mw0) + (hd_wr_cnt - hw0), 32'd0);

    // Zero-length request, then a 1-word load
    mw0 = mem_wr_cnt; hw0 = hd_wr_cnt;
    run(DIR_LOAD, 32'd0, MEM_ADDR_WIDTH'(0), CNT_WIDTH'(0), -1, done_at, err_at, busy_cycles);
    chk("zero_done_at", done_at, 32'd2);
    chk("zero_busy_cycles", busy_cycles, 32'd2);
    chk("zero_writes", (mem_wr_cnt - mw0) + (hd_wr_cnt - hw0), 32'd0);
    disk_m[5] = 32'h55;
    run(DIR_LOAD, 32'd5, MEM_ADDR_WIDTH'(7), CNT_WIDTH'(1), -1, done_at, err_at, busy_cycles);
    chk("after_zero_done_at", done_at, 32'd4);
    chk("after_zero_m7", mem_m[7], 32'h55);

    // Second start during a 5-word transfer is ignored
    for (int i = 0; i < 5; i++) disk_m[10 + i] = 32'h1000 + 32'(i);
    mw0 = mem_wr_cnt; hw0 = hd_wr_cnt; dn0 = done_cnt;
    run(DIR_LOAD, 32'd10, MEM_ADDR_WIDTH'(300), CNT_WIDTH'(5), 4, done_at, err_at, busy_cycles);
    chk("busy_start_done_at", done_at, 32'd12);
    chk("busy_start_mem_writes", mem_wr_cnt - mw0, 32'd5);
    chk("busy_start_hd_writes", hd_wr_cnt - hw0, 32'd0);
    chk("busy_start_done_pulses", done_cnt - dn0, 32'd1);
    chk("busy_start_m300", mem_m[300], 32'h1000);
    chk("busy_start_m304", mem_m[304], 32'h1004);

    // Reset during the WRITE of word 2 of an 8-word load
    for (int i = 0; i < 8; i++) begin
      disk_m[20 + i] = 32'h100 + 32'(i);
      mem_m[400 + i] = 32'hDEAD_0000 + 32'(i);
    end
    mw0 = mem_wr_cnt; dn0 = done_cnt;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.dir        = DIR_LOAD;
    bus.disk_base  = 32'd20;
    bus.mem_base   = MEM_ADDR_WIDTH'(400);
    bus.word_count = CNT_WIDTH'(8);
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_write", 32'(bus.mem_write), 32'h0);
    chk("mid_rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("mid_rst_mem_address", 32'(bus.mem_address), 32'h0);
    chk("mid_rst_hd_address", bus.hd_address, 32'h0);
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_rst_writes", mem_wr_cnt - mw0, 32'd2);
    chk("mid_rst_done_pulses", done_cnt - dn0, 32'd0);
    chk("mid_rst_m400", mem_m[400], 32'h100);
    chk("mid_rst_m401", mem_m[401], 32'h101);
    chk("mid_rst_m402", mem_m[402], 32'hDEAD_0002);
    chk("mid_rst_m407", mem_m[407], 32'hDEAD_0007);

    chk("never_both_writes", both_wr_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
